async_reset_sync_vec: RTL

//  Parametrised multi-channel synchroniser: WIDTH async inputs each pass through a DEPTH-flop chain into the

---
 rtl/async_reset_sync_vec.sv | 101 ++++++++++
 1 files changed

// File: rtl/async_reset_sync_vec.sv
// Multi-channel synchroniser: DEPTH-flop chain per channel, optional glitch filter,
// registered level output with rise/fall pulses and a post-reset ready flag.
module async_reset_sync_vec #(
    parameter int               WIDTH = 1,
    parameter int               DEPTH = 3,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int               FILT  = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             ready
);

    localparam int RDY_TERM = DEPTH + FILT + 1;
    localparam int RDY_W    = $clog2(DEPTH + FILT + 2);
    localparam logic [RDY_W-1:0] RDY_TC = RDY_W'(RDY_TERM);

    if (DEPTH < 2 || DEPTH > 8 || WIDTH < 1 || WIDTH > 64 || FILT < 0 || FILT > 255) begin : g_bad_param
        $error("async_reset_sync_vec: parameter out of range");
    end

    logic [WIDTH-1:0] stage [DEPTH];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] q_d;
    logic [RDY_W-1:0] rdy_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= INIT;
            end
        end else begin
            stage[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign sync = stage[DEPTH-1];

    if (FILT == 0) begin : g_nofilt
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                q <= INIT;
            end else begin
                q <= sync;
            end
        end
    end else begin : g_filt
        localparam logic [7:0] FILT_C = FILT[7:0];
        logic [7:0] cnt [WIDTH];

        // A channel only updates after sync disagrees with q for FILT+1 consecutive edges.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                q <= INIT;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt[i] <= '0;
                end
            end else begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (sync[i] == q[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == FILT_C) begin
                        q[i]   <= sync[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_d <= INIT;
        end else begin
            q_d <= q;
        end
    end

    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdy_cnt <= '0;
        end else if (rdy_cnt != RDY_TC) begin
            rdy_cnt <= rdy_cnt + RDY_W'(1);
        end
    end

    assign ready = (rdy_cnt == RDY_TC);

endmodule
